// File: rtl/lsu_mem_sequencer.sv
// lsu_mem_sequencer: one-at-a-time load/store sequencer between EX and a
// 64-bit data memory port. Builds aligned address, byte enables and lane-
// shifted store data, registers load responses for the load formatter,
// stalls the pipeline while busy and flags misalign / response timeouts.
//   clk, rst                 clock, async active-high reset
//   req_*                    EX-stage request (valid/ready)
//   mem_req_*, mem_*         memory request channel
//   mem_rsp_*                memory load response
//   rd_*                     captured fields for the load formatter
//   lsu_stall, misalign, timeout_err, done   status
module lsu_mem_sequencer #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic [2:0]  req_f3,
  input  logic        req_we,
  input  logic [63:0] req_wdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_be,
  output logic [63:0] mem_wdata,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rsp_data,
  output logic [63:0] rd_mem_data,
  output logic [7:0]  rd_be_mask,
  output logic [2:0]  rd_f3,
  output logic        rd_is_load_64,
  output logic        rd_valid_in,
  output logic        lsu_stall,
  output logic        misalign,
  output logic        timeout_err,
  output logic        done
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP,
    COMPLETE
  } state_t;

  state_t state, state_d;

  logic [63:0]   addr_q;
  logic [2:0]    f3_q;
  logic          we_q;
  logic [63:0]   wdata_q;
  logic [7:0]    be_q;
  logic [CW-1:0] cnt;

  logic [2:0] a_lo;
  logic       mis;
  logic [7:0] be_c;
  logic       accept;
  logic       timeout_hit;
  logic       rsp_take;

  assign a_lo   = req_addr[2:0];
  assign accept = req_valid & req_ready;

  // f3==111 is illegal and is rejected through the misalign path.
  always_comb begin
    mis  = 1'b0;
    be_c = 8'h00;
    unique case (1'b1)
      (req_f3 == 3'b111): begin
        mis = 1'b1;
      end
      (req_f3 == 3'b011): begin
        mis  = |a_lo;
        be_c = 8'hFF;
      end
      (req_f3[1:0] == 2'b00): begin
        be_c = 8'h01 << a_lo;
      end
      (req_f3[1:0] == 2'b01): begin
        mis  = a_lo[0];
        be_c = 8'h03 << a_lo;
      end
      (req_f3[1:0] == 2'b10): begin
        mis  = |a_lo[1:0];
        be_c = 8'h0F << a_lo;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // A response in the last counted cycle takes priority over timeout.
  always_comb begin
    state_d     = state;
    timeout_hit = 1'b0;
    rsp_take    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept && !mis) state_d = ISSUE;
      end
      ISSUE: begin
        if (mem_req_ready) state_d = we_q ? COMPLETE : WAIT_RSP;
      end
      WAIT_RSP: begin
        if (mem_rsp_valid) begin
          rsp_take = 1'b1;
          state_d  = COMPLETE;
        end else if (cnt == CNT_LAST) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end
      end
      COMPLETE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      f3_q        <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
      cnt         <= '0;
      rd_mem_data <= '0;
      misalign    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      misalign    <= accept & mis;
      timeout_err <= timeout_hit;
      if (accept) begin
        addr_q  <= {req_addr[63:3], 3'b000};
        f3_q    <= req_f3;
        we_q    <= req_we;
        wdata_q <= req_wdata << {a_lo, 3'b000};
        be_q    <= be_c;
      end
      if (state == WAIT_RSP) cnt <= cnt + CW'(1);
      else                   cnt <= '0;
      if (rsp_take) rd_mem_data <= mem_rsp_data;
    end
  end

  assign req_ready     = (state == IDLE);
  assign mem_req_valid = (state == ISSUE);
  assign mem_addr      = addr_q;
  assign mem_we        = we_q & mem_req_valid;
  assign mem_be        = be_q;
  assign mem_wdata     = wdata_q;
  assign rd_be_mask    = be_q;
  assign rd_f3         = f3_q;
  assign rd_is_load_64 = (f3_q == 3'b011);
  assign done          = (state == COMPLETE);
  assign rd_valid_in   = done & ~we_q;
  assign lsu_stall     = (state != IDLE) | (accept & ~mis);

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// tb_lsu_mem_sequencer: directed self-checking bench for lsu_mem_sequencer.
// Runs with TIMEOUT_CYCLES=8; expected values are hand-computed constants.
module tb_lsu_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [2:0]  req_f3;
  logic        req_we;
  logic [63:0] req_wdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_be;
  logic [63:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic [63:0] rd_mem_data;
  logic [7:0]  rd_be_mask;
  logic [2:0]  rd_f3;
  logic        rd_is_load_64;
  logic        rd_valid_in;
  logic        lsu_stall;
  logic        misalign;
  logic        timeout_err;
  logic        done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_mem_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_f3        (req_f3),
    .req_we        (req_we),
    .req_wdata     (req_wdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_be        (mem_be),
    .mem_wdata     (mem_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .rd_mem_data   (rd_mem_data),
    .rd_be_mask    (rd_be_mask),
    .rd_f3         (rd_f3),
    .rd_is_load_64 (rd_is_load_64),
    .rd_valid_in   (rd_valid_in),
    .lsu_stall     (lsu_stall),
    .misalign      (misalign),
    .timeout_err   (timeout_err),
    .done          (done)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Step to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Settle to the falling edge before sampling outputs.
  task automatic settle();
    @(negedge clk);
  endtask

  task automatic req(input logic [63:0] a, input logic [2:0] f3,
                     input logic we, input logic [63:0] wd);
    req_valid = 1'b1;
    req_addr  = a;
    req_f3    = f3;
    req_we    = we;
    req_wdata = wd;
  endtask

  initial begin
    rst           = 1'b1;
    req_valid     = 1'b0;
    req_addr      = '0;
    req_f3        = '0;
    req_we        = 1'b0;
    req_wdata     = '0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;

    settle();
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_stall", 64'(lsu_stall), 64'd0);
    check("rst_mvalid", 64'(mem_req_valid), 64'd0);
    check("rst_rdata", rd_mem_data, 64'd0);
    tick();
    rst = 1'b0;

    // 1: LB 0x1003, one-cycle memory
    tick();
    req(64'h1003, 3'b000, 1'b0, 64'd0);
    settle();
    check("t1_c0_stall", 64'(lsu_stall), 64'd1);
    tick();
    req_valid = 1'b0;
    settle();
    check("t1_c1_mvalid", 64'(mem_req_valid), 64'd1);
    check("t1_c1_addr", mem_addr, 64'h1000);
    check("t1_c1_be", 64'(mem_be), 64'h08);
    check("t1_c1_we", 64'(mem_we), 64'd0);
    check("t1_c1_ready", 64'(req_ready), 64'd0);
    tick();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'h8877665544332211;
    settle();
    check("t1_c2_mvalid", 64'(mem_req_valid), 64'd0);
    check("t1_c2_rdv", 64'(rd_valid_in), 64'd0);
    tick();
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    settle();
    check("t1_c3_rdv", 64'(rd_valid_in), 64'd1);
    check("t1_c3_done", 64'(done), 64'd1);
    check("t1_c3_data", rd_mem_data, 64'h8877665544332211);
    check("t1_c3_mask", 64'(rd_be_mask), 64'h08);
    check("t1_c3_f3", 64'(rd_f3), 64'd0);
    check("t1_c3_ld64", 64'(rd_is_load_64), 64'd0);
    tick();
    settle();
    check("t1_c4_rdv", 64'(rd_valid_in), 64'd0);
    check("t1_c4_ready", 64'(req_ready), 64'd1);

    // 2: SH 0x2006
    tick();
    req(64'h2006, 3'b001, 1'b1, 64'hBEEF);
    settle();
    tick();
    req_valid = 1'b0;
    settle();
    check("t2_c1_be", 64'(mem_be), 64'hC0);
    check("t2_c1_wdata", mem_wdata, 64'hBEEF000000000000);
    check("t2_c1_we", 64'(mem_we), 64'd1);
    check("t2_c1_addr", mem_addr, 64'h2000);
    tick();
    settle();
    check("t2_c2_done", 64'(done), 64'd1);
    check("t2_c2_rdv", 64'(rd_valid_in), 64'd0);
    tick();
    settle();
    check("t2_c3_done", 64'(done), 64'd0);

    // 3: LW 0x3002 misaligned
    tick();
    req(64'h3002, 3'b010, 1'b0, 64'd0);
    settle();
    check("t3_c0_stall", 64'(lsu_stall), 64'd0);
    tick();
    req_valid = 1'b0;
    settle();
    check("t3_c1_mis", 64'(misalign), 64'd1);
    check("t3_c1_mvalid", 64'(mem_req_valid), 64'd0);
    check("t3_c1_ready", 64'(req_ready), 64'd1);
    tick();
    settle();
    check("t3_c2_mis", 64'(misalign), 64'd0);
    check("t3_c2_mvalid", 64'(mem_req_valid), 64'd0);

    // 4: LD 0x4000 with no response
    tick();
    req(64'h4000, 3'b011, 1'b0, 64'd0);
    settle();
    tick();
    req_valid = 1'b0;
    settle();
    check("t4_c1_be", 64'(mem_be), 64'hFF);
    for (int i = 2; i <= 9; i++) begin
      tick();
      settle();
      check($sformatf("t4_c%0d_stall", i), 64'(lsu_stall), 64'd1);
      check($sformatf("t4_c%0d_to", i), 64'(timeout_err), 64'd0);
    end
    tick();
    settle();
    check("t4_c10_to", 64'(timeout_err), 64'd1);
    check("t4_c10_ready", 64'(req_ready), 64'd1);
    check("t4_c10_ld64", 64'(rd_is_load_64), 64'd1);
    tick();
    settle();
    check("t4_c11_to", 64'(timeout_err), 64'd0);
    tick();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'hDEADBEEFCAFEF00D;
    settle();
    tick();
    mem_rsp_valid = 1'b0;
    settle();
    check("t4_late_rdv", 64'(rd_valid_in), 64'd0);
    check("t4_late_done", 64'(done), 64'd0);
    check("t4_late_data", rd_mem_data, 64'h8877665544332211);

    // 5: SD 0x5008, memory not ready for 5 cycles
    tick();
    req(64'h5008, 3'b011, 1'b1, 64'h0123456789ABCDEF);
    mem_req_ready = 1'b0;
    settle();
    for (int i = 1; i <= 5; i++) begin
      tick();
      req_valid = 1'b0;
      settle();
      check($sformatf("t5_c%0d_mv", i), 64'(mem_req_valid), 64'd1);
      check($sformatf("t5_c%0d_addr", i), mem_addr, 64'h5008);
      check($sformatf("t5_c%0d_be", i), 64'(mem_be), 64'hFF);
      check($sformatf("t5_c%0d_stall", i), 64'(lsu_stall), 64'd1);
    end
    tick();
    mem_req_ready = 1'b1;
    settle();
    check("t5_c6_wdata", mem_wdata, 64'h0123456789ABCDEF);
    check("t5_c6_done", 64'(done), 64'd0);
    tick();
    settle();
    check("t5_c7_done", 64'(done), 64'd1);
    check("t5_c7_rdv", 64'(rd_valid_in), 64'd0);

    // 6: reset while in WAIT_RSP, then LBU 0x10
    tick();
    req(64'h6000, 3'b010, 1'b0, 64'd0);
    settle();
    tick();
    req_valid = 1'b0;
    settle();
    tick();
    settle();
    check("t6_wait_stall", 64'(lsu_stall), 64'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_ready", 64'(req_ready), 64'd1);
    check("t6_rst_stall", 64'(lsu_stall), 64'd0);
    check("t6_rst_addr", mem_addr, 64'd0);
    check("t6_rst_be", 64'(mem_be), 64'd0);
    check("t6_rst_rdata", rd_mem_data, 64'd0);
    check("t6_rst_pulses",
          64'({mem_req_valid, done, rd_valid_in, misalign, timeout_err}),
          64'd0);
    tick();
    rst = 1'b0;
    tick();
    req(64'h10, 3'b100, 1'b0, 64'd0);
    settle();
    tick();
    req_valid = 1'b0;
    settle();
    check("t6_c1_addr", mem_addr, 64'h10);
    check("t6_c1_be", 64'(mem_be), 64'h01);
    tick();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'h00000000000000AB;
    settle();
    tick();
    mem_rsp_valid = 1'b0;
    settle();
    check("t6_c3_rdv", 64'(rd_valid_in), 64'd1);
    check("t6_c3_data", rd_mem_data, 64'hAB);
    check("t6_c3_f3", 64'(rd_f3), 64'd4);
    check("t6_c3_mask", 64'(rd_be_mask), 64'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
